// File: rtl/sample_recorder.sv
// Sample recorder: captures the live audio stream into on-chip RAM on the sample tick,
// then plays the captured take back out (looping or one-shot).
module sample_recorder #(
   parameter  int DEPTH  = 4096,
   parameter  int DATA_W = 8,
   parameter  int LOOP   = 1,
   localparam int ADDR_W = $clog2(DEPTH),
   localparam int LEN_W  = ADDR_W + 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sample_tick,
   input  logic              rec,
   input  logic              play,
   input  logic [DATA_W-1:0] din,
   output logic [DATA_W-1:0] dout,
   output logic [LEN_W-1:0]  len,
   output logic              full,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REC  = 2'b01,
      ST_PLAY = 2'b10
   } state_t;

   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
   localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(DEPTH);

   state_t              state_r;
   state_t              state_nxt_s;
   logic                rec_q_r;
   logic                play_q_r;
   logic [ADDR_W-1:0]   wr_ptr_r;
   logic [ADDR_W-1:0]   wr_ptr_nxt_s;
   logic [ADDR_W-1:0]   rd_ptr_r;
   logic [ADDR_W-1:0]   rd_ptr_nxt_s;
   logic [LEN_W-1:0]    len_r;
   logic [LEN_W-1:0]    len_nxt_s;
   logic                full_r;
   logic                full_nxt_s;
   logic [DATA_W-1:0]   dout_r;
   logic                wr_en_s;
   logic                rd_en_s;
   logic                dout_clr_s;
   logic                rec_rise_s;
   logic                play_rise_s;
   logic                last_s;
   logic [DATA_W-1:0]   mem_r [DEPTH];

   assign rec_rise_s  = rec & ~rec_q_r;
   assign play_rise_s = play & ~play_q_r;
   // Pointer comparison is done at LEN_W so len == DEPTH cannot overflow.
   assign last_s      = (({1'b0, rd_ptr_r} + LEN_ONE) == len_r);

   // Next-state, pointer and datapath-strobe decode.
   always_comb begin
      state_nxt_s  = state_r;
      wr_ptr_nxt_s = wr_ptr_r;
      rd_ptr_nxt_s = rd_ptr_r;
      len_nxt_s    = len_r;
      full_nxt_s   = full_r;
      wr_en_s      = 1'b0;
      rd_en_s      = 1'b0;
      dout_clr_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            dout_clr_s = 1'b1;
            if (rec_rise_s) begin
               state_nxt_s  = ST_REC;
               wr_ptr_nxt_s = ADDR_ZERO;
               len_nxt_s    = LEN_ZERO;
               full_nxt_s   = 1'b0;
            end else if (play_rise_s && (len_r != LEN_ZERO)) begin
               state_nxt_s  = ST_PLAY;
               rd_ptr_nxt_s = ADDR_ZERO;
            end else begin
               state_nxt_s  = ST_IDLE;
            end
         end
         ST_REC: begin
            if (!rec) begin
               // Release wins over a coincident tick: the take ends without a write.
               state_nxt_s = ST_IDLE;
               len_nxt_s   = {1'b0, wr_ptr_r};
               dout_clr_s  = 1'b1;
            end else if (sample_tick) begin
               wr_en_s      = 1'b1;
               wr_ptr_nxt_s = wr_ptr_r + ADDR_ONE;
               len_nxt_s    = {1'b0, wr_ptr_r} + LEN_ONE;
               if (wr_ptr_r == ADDR_LAST) begin
                  full_nxt_s  = 1'b1;
                  len_nxt_s   = LEN_FULL;
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_REC;
               end
            end else begin
               state_nxt_s = ST_REC;
            end
         end
         ST_PLAY: begin
            if (!play) begin
               state_nxt_s = ST_IDLE;
               dout_clr_s  = 1'b1;
            end else if (sample_tick) begin
               rd_en_s = 1'b1;
               if (last_s) begin
                  if (LOOP != 0) begin
                     rd_ptr_nxt_s = ADDR_ZERO;
                     state_nxt_s  = ST_PLAY;
                  end else begin
                     state_nxt_s  = ST_IDLE;
                  end
               end else begin
                  rd_ptr_nxt_s = rd_ptr_r + ADDR_ONE;
                  state_nxt_s  = ST_PLAY;
               end
            end else begin
               state_nxt_s = ST_PLAY;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
            dout_clr_s  = 1'b1;
         end
      endcase
   end

   // Control state, pointers, take length and edge-detect history.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         rec_q_r  <= 1'b0;
         play_q_r <= 1'b0;
         wr_ptr_r <= ADDR_ZERO;
         rd_ptr_r <= ADDR_ZERO;
         len_r    <= LEN_ZERO;
         full_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt_s;
         rec_q_r  <= rec;
         play_q_r <= play;
         wr_ptr_r <= wr_ptr_nxt_s;
         rd_ptr_r <= rd_ptr_nxt_s;
         len_r    <= len_nxt_s;
         full_r   <= full_nxt_s;
      end
   end

   // Sample RAM write port; contents survive reset.
   always_ff @(posedge clk) begin
      if (wr_en_s) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   // Output sample: synchronous RAM read during play, input monitor during record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_r <= {DATA_W{1'b0}};
      end else if (rd_en_s) begin
         dout_r <= mem_r[rd_ptr_r];
      end else if (wr_en_s) begin
         dout_r <= din;
      end else if (dout_clr_s) begin
         dout_r <= {DATA_W{1'b0}};
      end else begin
         dout_r <= dout_r;
      end
   end

   assign dout  = dout_r;
   assign len   = len_r;
   assign full  = full_r;
   assign state = state_r;

endmodule

// File: tb/tb_sample_recorder.sv
// Bench for sample_recorder: a looping and a one-shot instance (DEPTH=16), a per-cycle
// vector table for record/play, plus scoreboarded sequences for fill, reset and one-shot.
module tb_sample_recorder;

   typedef struct {
      logic       rec;
      logic       play;
      logic       tick;
      logic [7:0] din;
      logic [1:0] st;
      logic [4:0] len;
      logic       full;
      logic [7:0] dout;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [7:0] din = 8'd0;
   logic       rec_a = 1'b0, play_a = 1'b0, rec_b = 1'b0, play_b = 1'b0;
   logic [7:0] dout_a, dout_b;
   logic [4:0] len_a, len_b;
   logic       full_a, full_b;
   logic [1:0] state_a, state_b;

   int         checks = 0;
   int         failures = 0;
   logic [7:0] sbq [$];
   vec_t       vecs [30];
   logic [7:0] take [3];

   always #5 clk = ~clk;

   sample_recorder #(.DEPTH(16), .DATA_W(8), .LOOP(1)) u_loop (
      .clk(clk), .rst_n(rst_n), .sample_tick(tick), .rec(rec_a), .play(play_a),
      .din(din), .dout(dout_a), .len(len_a), .full(full_a), .state(state_a)
   );

   sample_recorder #(.DEPTH(16), .DATA_W(8), .LOOP(0)) u_oneshot (
      .clk(clk), .rst_n(rst_n), .sample_tick(tick), .rec(rec_b), .play(play_b),
      .din(din), .dout(dout_b), .len(len_b), .full(full_b), .state(state_b)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic sb_pop(input string name, input logic [7:0] act);
      logic [7:0] e;
      if (sbq.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s: got %0d expected nothing (scoreboard empty)", name, act);
      end else begin
         e = sbq.pop_front();
         chk(name, int'(act), int'(e));
      end
   endtask

   initial begin
      //          rec   play  tick  din    state  len   full  dout
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b01, 5'd0, 1'b0, 8'd0};
      vecs[1]  = '{1'b1, 1'b0, 1'b1, 8'd11, 2'b01, 5'd1, 1'b0, 8'd11};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b01, 5'd1, 1'b0, 8'd11};
      vecs[3]  = '{1'b1, 1'b0, 1'b1, 8'd22, 2'b01, 5'd2, 1'b0, 8'd22};
      vecs[4]  = '{1'b1, 1'b0, 1'b1, 8'd33, 2'b01, 5'd3, 1'b0, 8'd33};
      vecs[5]  = '{1'b1, 1'b0, 1'b1, 8'd44, 2'b01, 5'd4, 1'b0, 8'd44};
      vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'd55, 2'b01, 5'd5, 1'b0, 8'd55};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 5'd5, 1'b0, 8'd0};
      vecs[8]  = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b10, 5'd5, 1'b0, 8'd0};
      vecs[9]  = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd11};
      vecs[10] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd22};
      vecs[11] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd33};
      vecs[12] = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b10, 5'd5, 1'b0, 8'd33};
      vecs[13] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd44};
      vecs[14] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd55};
      vecs[15] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd11};
      vecs[16] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd5, 1'b0, 8'd22};
      vecs[17] = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 5'd5, 1'b0, 8'd0};
      vecs[18] = '{1'b0, 1'b0, 1'b1, 8'd99, 2'b00, 5'd5, 1'b0, 8'd0};
      vecs[19] = '{1'b1, 1'b0, 1'b0, 8'd0,  2'b01, 5'd0, 1'b0, 8'd0};
      vecs[20] = '{1'b1, 1'b0, 1'b1, 8'd77, 2'b01, 5'd1, 1'b0, 8'd77};
      vecs[21] = '{1'b0, 1'b0, 1'b1, 8'd88, 2'b00, 5'd1, 1'b0, 8'd0};
      vecs[22] = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b10, 5'd1, 1'b0, 8'd0};
      vecs[23] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd1, 1'b0, 8'd77};
      vecs[24] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b10, 5'd1, 1'b0, 8'd77};
      vecs[25] = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 5'd1, 1'b0, 8'd0};
      vecs[26] = '{1'b1, 1'b1, 1'b0, 8'd0,  2'b01, 5'd0, 1'b0, 8'd0};
      vecs[27] = '{1'b0, 1'b1, 1'b0, 8'd0,  2'b00, 5'd0, 1'b0, 8'd0};
      vecs[28] = '{1'b0, 1'b1, 1'b1, 8'd0,  2'b00, 5'd0, 1'b0, 8'd0};
      vecs[29] = '{1'b0, 1'b0, 1'b0, 8'd0,  2'b00, 5'd0, 1'b0, 8'd0};
      take[0] = 8'd11;
      take[1] = 8'd22;
      take[2] = 8'd33;

      // Reset state
      step();
      step();
      chk("rst_state_a", int'(state_a), 0);
      chk("rst_len_a", int'(len_a), 0);
      chk("rst_full_a", int'(full_a), 0);
      chk("rst_dout_a", int'(dout_a), 0);
      chk("rst_state_b", int'(state_b), 0);
      chk("rst_len_b", int'(len_b), 0);
      rst_n = 1'b1;

      // Per-cycle table: record 5, loop play 7, same-cycle corner cases
      for (int i = 0; i < 30; i++) begin
         rec_a  = vecs[i].rec;
         play_a = vecs[i].play;
         tick   = vecs[i].tick;
         din    = vecs[i].din;
         step();
         chk($sformatf("vec%0d_state", i), int'(state_a), int'(vecs[i].st));
         chk($sformatf("vec%0d_len", i), int'(len_a), int'(vecs[i].len));
         chk($sformatf("vec%0d_full", i), int'(full_a), int'(vecs[i].full));
         chk($sformatf("vec%0d_dout", i), int'(dout_a), int'(vecs[i].dout));
      end
      rec_a = 1'b0; play_a = 1'b0; tick = 1'b0; din = 8'd0;
      step();

      // Fill: hold rec through 20 ticks, RAM stops at 16 samples
      rec_a = 1'b1;
      step();
      chk("fill_start_state", int'(state_a), 1);
      for (int i = 0; i < 20; i++) begin
         din  = 8'(i);
         tick = 1'b1;
         step();
         chk($sformatf("fill%0d_state", i), int'(state_a), (i < 15) ? 1 : 0);
         chk($sformatf("fill%0d_len", i), int'(len_a), (i < 15) ? i + 1 : 16);
         chk($sformatf("fill%0d_full", i), int'(full_a), (i < 15) ? 0 : 1);
      end
      tick = 1'b0; rec_a = 1'b0;
      step();
      play_a = 1'b1;
      step();
      chk("fill_play_state", int'(state_a), 2);
      for (int i = 0; i < 18; i++) begin
         sbq.push_back(8'(i % 16));
         tick = 1'b1;
         step();
         sb_pop($sformatf("fill_rd%0d", i), dout_a);
      end
      tick = 1'b0; play_a = 1'b0;
      step();
      chk("fill_stop_dout", int'(dout_a), 0);
      chk("fill_stop_state", int'(state_a), 0);

      // Reset asserted during the third playback tick
      play_a = 1'b1;
      step();
      chk("rstp_play_state", int'(state_a), 2);
      for (int i = 0; i < 2; i++) begin
         sbq.push_back(8'(i));
         tick = 1'b1;
         step();
         sb_pop($sformatf("rstp_rd%0d", i), dout_a);
      end
      tick = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rstp_state", int'(state_a), 0);
      chk("rstp_len", int'(len_a), 0);
      chk("rstp_full", int'(full_a), 0);
      chk("rstp_dout", int'(dout_a), 0);
      step();
      rst_n = 1'b1;
      tick  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick = i[0];
         step();
         chk($sformatf("rstp_hold%0d_state", i), int'(state_a), 0);
      end
      play_a = 1'b0; tick = 1'b0;
      step();

      // One-shot instance: play with empty take ignored, then 3-sample take
      play_b = 1'b1;
      step();
      chk("os_empty_play_state", int'(state_b), 0);
      play_b = 1'b0;
      step();
      rec_b = 1'b1;
      step();
      chk("os_rec_state", int'(state_b), 1);
      for (int i = 0; i < 3; i++) begin
         din  = take[i];
         tick = 1'b1;
         step();
      end
      tick = 1'b0; rec_b = 1'b0;
      step();
      chk("os_len", int'(len_b), 3);
      chk("os_idle_state", int'(state_b), 0);
      play_b = 1'b1;
      step();
      chk("os_play_state", int'(state_b), 2);
      for (int i = 0; i < 3; i++) begin
         sbq.push_back(take[i]);
         tick = 1'b1;
         step();
         sb_pop($sformatf("os_rd%0d", i), dout_b);
      end
      chk("os_end_state", int'(state_b), 0);
      tick = 1'b0;
      step();
      chk("os_after_dout", int'(dout_b), 0);
      tick = 1'b1;
      step();
      chk("os_no_replay_dout", int'(dout_b), 0);
      chk("os_no_replay_state", int'(state_b), 0);
      tick = 1'b0; play_b = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
